// File: rtl/csr_unit_pkg.sv
// Shared definitions for csr_unit: CSR addresses, Zicsr op encodings, status/pending bit positions.
// CSR_TIMER_EN selects the built-in mtime/mtimecmp timer in csr_unit.
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MTIME     = 12'h7C0;
    localparam logic [11:0] CSR_MTIMECMP  = 12'h7C1;
    localparam logic [11:0] CSR_MTIMEH    = 12'h7C2;
    localparam logic [11:0] CSR_MTIMECMPH = 12'h7C3;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP  = 11;
    localparam int MIP_MSIP     = 3;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [11:0] MIE_WMASK = 12'h888;

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit counter with increment enable and low/high/full write ports.
// Any write takes priority over the increment for the whole counter.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_full,
    input  logic [63:0] wdata,
    output logic [63:0] value
);

    logic [63:0] cnt_r;

    // Counter state: write ports first, otherwise increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 64'd0;
        end else if (wr_full) begin
            cnt_r <= wdata;
        end else if (wr_lo) begin
            cnt_r <= {cnt_r[63:32], wdata[31:0]};
        end else if (wr_hi) begin
            cnt_r <= {wdata[31:0], cnt_r[31:0]};
        end else if (inc) begin
            cnt_r <= cnt_r + 64'd1;
        end
    end

    assign value = cnt_r;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: Zicsr RW/RS/RC access, trap/mret state, interrupts, counters.
// Define CSR_TIMER_EN to add mtime/mtimecmp at 0x7C0-0x7C3 driving MTIP.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int                XLEN        = 32,
    parameter int                HART_ID     = 0,
    parameter logic [31:0]       MISA_VAL    = 32'h4000_0100,
    parameter logic [XLEN-1:0]   MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_req_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            csr_ack_o,
    output logic            csr_illegal_o,
    input  logic            inst_retire_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] trap_vector_o,
    output logic [XLEN-1:0] mepc_o,
    input  logic            irq_ext_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    output logic            irq_pending_o
);

    localparam bit              IS32       = (XLEN == 32);
    localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};
    localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mie_bit_r, mpie_r;
    logic [11:0]     mie_r;
    logic [XLEN-1:0] mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [XLEN-1:0] rdata_r;
    logic            ack_r, illegal_r, irq_pending_r;

    logic [XLEN-1:0] old_s, wval_s, tvec_base_s;
    logic            known_s, write_en_s, illegal_s, do_write_s, mtip_s;
    logic [12:0]     mstatus_s;
    logic [11:0]     mip_s;
    logic [63:0]     wdata64_s, mcycle_s, minstret_s;

    // Architectural views of mstatus and mip.
    always_comb begin
        mstatus_s = 13'd0;
        mstatus_s[MSTATUS_MIE]        = mie_bit_r;
        mstatus_s[MSTATUS_MPIE]       = mpie_r;
        mstatus_s[MSTATUS_MPP+1 -: 2] = 2'b11;
        mip_s = 12'd0;
        mip_s[MIP_MSIP] = irq_sw_i;
        mip_s[MIP_MTIP] = mtip_s;
        mip_s[MIP_MEIP] = irq_ext_i;
    end

`ifdef CSR_TIMER_EN
    logic [63:0] mtime_s, mtimecmp_r;

    csr_counter64 u_mtime (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .wr_lo   (IS32 && do_write_s && (csr_addr_i == CSR_MTIME)),
        .wr_hi   (IS32 && do_write_s && (csr_addr_i == CSR_MTIMEH)),
        .wr_full (!IS32 && do_write_s && (csr_addr_i == CSR_MTIME)),
        .wdata   (wdata64_s),
        .value   (mtime_s)
    );

    // mtimecmp resets to all-ones so the timer is quiet until programmed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp_r <= {64{1'b1}};
        end else if (do_write_s && (csr_addr_i == CSR_MTIMECMP)) begin
            mtimecmp_r <= IS32 ? {mtimecmp_r[63:32], wdata64_s[31:0]} : wdata64_s;
        end else if (IS32 && do_write_s && (csr_addr_i == CSR_MTIMECMPH)) begin
            mtimecmp_r <= {wdata64_s[31:0], mtimecmp_r[31:0]};
        end
    end

    assign mtip_s = (mtime_s >= mtimecmp_r);
`else
    assign mtip_s = irq_timer_i;
`endif

    // Old-value read mux and address decode.
    always_comb begin
        old_s   = '0;
        known_s = 1'b1;
        case (csr_addr_i)
            CSR_MSTATUS:  old_s = XLEN'(mstatus_s);
            CSR_MISA:     old_s = XLEN'(MISA_VAL);
            CSR_MIE:      old_s = XLEN'(mie_r);
            CSR_MTVEC:    old_s = mtvec_r;
            CSR_MSCRATCH: old_s = mscratch_r;
            CSR_MEPC:     old_s = mepc_r;
            CSR_MCAUSE:   old_s = mcause_r;
            CSR_MTVAL:    old_s = mtval_r;
            CSR_MIP:      old_s = XLEN'(mip_s);
            CSR_MCYCLE:   old_s = mcycle_s[XLEN-1:0];
            CSR_MINSTRET: old_s = minstret_s[XLEN-1:0];
            CSR_MCYCLEH: begin
                if (IS32) old_s = XLEN'(mcycle_s[63:32]);
                else      known_s = 1'b0;
            end
            CSR_MINSTRETH: begin
                if (IS32) old_s = XLEN'(minstret_s[63:32]);
                else      known_s = 1'b0;
            end
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: old_s = '0;
            CSR_MHARTID:  old_s = XLEN'(HART_ID);
`ifdef CSR_TIMER_EN
            CSR_MTIME:    old_s = mtime_s[XLEN-1:0];
            CSR_MTIMECMP: old_s = mtimecmp_r[XLEN-1:0];
            CSR_MTIMEH: begin
                if (IS32) old_s = XLEN'(mtime_s[63:32]);
                else      known_s = 1'b0;
            end
            CSR_MTIMECMPH: begin
                if (IS32) old_s = XLEN'(mtimecmp_r[63:32]);
                else      known_s = 1'b0;
            end
`endif
            default:      known_s = 1'b0;
        endcase
    end

    // New value and whether the access performs a write at all.
    always_comb begin
        wval_s     = '0;
        write_en_s = 1'b0;
        case (csr_op_e'(csr_op_i))
            CSR_OP_RW: begin
                wval_s     = csr_wdata_i;
                write_en_s = 1'b1;
            end
            CSR_OP_RS: begin
                wval_s     = old_s | csr_wdata_i;
                write_en_s = (csr_wdata_i != '0);
            end
            CSR_OP_RC: begin
                wval_s     = old_s & ~csr_wdata_i;
                write_en_s = (csr_wdata_i != '0);
            end
            default: begin
                wval_s     = '0;
                write_en_s = 1'b0;
            end
        endcase
    end

    assign illegal_s  = csr_req_i && (!known_s || (write_en_s && (csr_addr_i[11:10] == 2'b11)));
    assign do_write_s = csr_req_i && write_en_s && !illegal_s && !trap_i && !mret_i;
    assign wdata64_s  = 64'(wval_s);

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .wr_lo   (IS32 && do_write_s && (csr_addr_i == CSR_MCYCLE)),
        .wr_hi   (IS32 && do_write_s && (csr_addr_i == CSR_MCYCLEH)),
        .wr_full (!IS32 && do_write_s && (csr_addr_i == CSR_MCYCLE)),
        .wdata   (wdata64_s),
        .value   (mcycle_s)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (inst_retire_i),
        .wr_lo   (IS32 && do_write_s && (csr_addr_i == CSR_MINSTRET)),
        .wr_hi   (IS32 && do_write_s && (csr_addr_i == CSR_MINSTRETH)),
        .wr_full (!IS32 && do_write_s && (csr_addr_i == CSR_MINSTRET)),
        .wdata   (wdata64_s),
        .value   (minstret_s)
    );

    // Trap state and CSR storage; trap beats mret beats a CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_bit_r  <= 1'b0;
            mpie_r     <= 1'b0;
            mie_r      <= 12'd0;
            mtvec_r    <= MTVEC_RESET;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
        end else if (trap_i) begin
            mepc_r    <= trap_pc_i & MEPC_MASK;
            mcause_r  <= trap_cause_i;
            mtval_r   <= trap_tval_i;
            mpie_r    <= mie_bit_r;
            mie_bit_r <= 1'b0;
        end else if (mret_i) begin
            mie_bit_r <= mpie_r;
            mpie_r    <= 1'b1;
        end else if (do_write_s) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mie_bit_r <= wval_s[MSTATUS_MIE];
                    mpie_r    <= wval_s[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_r      <= wval_s[11:0] & MIE_WMASK;
                CSR_MTVEC:    mtvec_r    <= wval_s & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_r <= wval_s;
                CSR_MEPC:     mepc_r     <= wval_s & MEPC_MASK;
                CSR_MCAUSE:   mcause_r   <= wval_s;
                CSR_MTVAL:    mtval_r    <= wval_s;
                default:      ;
            endcase
        end
    end

    // Registered response and interrupt-pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r         <= 1'b0;
            illegal_r     <= 1'b0;
            rdata_r       <= '0;
            irq_pending_r <= 1'b0;
        end else begin
            ack_r         <= csr_req_i;
            illegal_r     <= illegal_s;
            rdata_r       <= (csr_req_i && !illegal_s) ? old_s : '0;
            irq_pending_r <= mie_bit_r && ((mip_s & mie_r) != 12'd0);
        end
    end

    assign tvec_base_s   = {mtvec_r[XLEN-1:2], 2'b00};
    assign trap_vector_o = (mtvec_r[0] && trap_cause_i[XLEN-1])
                         ? tvec_base_s + {trap_cause_i[XLEN-3:0], 2'b00}
                         : tvec_base_s;
    assign mepc_o        = mepc_r;
    assign csr_rdata_o   = rdata_r;
    assign csr_ack_o     = ack_r;
    assign csr_illegal_o = illegal_r;
    assign irq_pending_o = irq_pending_r;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: randomized accesses against a table-driven CSR model,
// then directed trap/mret/illegal/counter/interrupt/reset steps.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_req = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'h000;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        csr_ack, csr_illegal;
    logic        inst_retire = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_pc = 32'h0, trap_cause = 32'h0, trap_tval = 32'h0;
    logic        mret = 1'b0;
    logic [31:0] trap_vector, mepc;
    logic        irq_ext = 1'b0, irq_sw = 1'b0, irq_timer = 1'b0;
    logic        irq_pending;

    int compared = 0;
    int mismatched = 0;

    csr_unit #(.XLEN(32), .HART_ID(5), .MISA_VAL(32'h4000_0100), .MTVEC_RESET(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_req_i(csr_req), .csr_op_i(csr_op), .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
        .csr_rdata_o(csr_rdata), .csr_ack_o(csr_ack), .csr_illegal_o(csr_illegal),
        .inst_retire_i(inst_retire), .trap_i(trap), .trap_pc_i(trap_pc),
        .trap_cause_i(trap_cause), .trap_tval_i(trap_tval), .mret_i(mret),
        .trap_vector_o(trap_vector), .mepc_o(mepc),
        .irq_ext_i(irq_ext), .irq_sw_i(irq_sw), .irq_timer_i(irq_timer),
        .irq_pending_o(irq_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $error("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One CSR access; returns the response sampled just after the capturing edge.
    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ill, output logic ack);
        @(negedge clk);
        csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
        @(posedge clk);
        #1;
        rd = csr_rdata; ill = csr_illegal; ack = csr_ack;
        csr_req = 1'b0; csr_op = 2'b00; csr_wdata = 32'h0;
    endtask

    // Reference CSR model: per-address value and writable-bit mask.
    logic [31:0] mdl [logic [11:0]];

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h301: return 32'h0000_0000;
            12'h344: return 32'h0000_0000;
            12'h304: return 32'h0000_0888;
            12'h305: return 32'hFFFF_FFFD;
            12'h341: return 32'hFFFF_FFFC;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [11:0] pool [15] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7FF, 12'h123};

    initial begin
        logic [31:0] rd, wd, expv, newv;
        logic        ill, ack, known, we, expill;
        logic [11:0] a;
        logic [1:0]  op;
        bit          seen;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", 32'(csr_ack), 32'h0);
        check("reset_rdata", csr_rdata, 32'h0);
        check("reset_illegal", 32'(csr_illegal), 32'h0);
        check("reset_pending", 32'(irq_pending), 32'h0);
        check("reset_mepc", mepc, 32'h0);
        check("reset_tvec", trap_vector, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Randomized accesses against the model
        mdl[12'h300] = 32'h0000_1800; mdl[12'h301] = 32'h4000_0100;
        mdl[12'h304] = 32'h0; mdl[12'h305] = 32'h0; mdl[12'h340] = 32'h0; mdl[12'h341] = 32'h0;
        mdl[12'h342] = 32'h0; mdl[12'h343] = 32'h0; mdl[12'h344] = 32'h0;
        mdl[12'hF11] = 32'h0; mdl[12'hF12] = 32'h0; mdl[12'hF13] = 32'h0; mdl[12'hF14] = 32'h5;
        for (int i = 0; i < 200; i++) begin
            a  = pool[$urandom_range(0, 14)];
            op = 2'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            known  = mdl.exists(a);
            we     = (op == 2'b01) || ((op != 2'b00) && (wd != 32'h0));
            expill = !known || (we && (a[11:10] == 2'b11));
            expv   = expill ? 32'h0 : mdl[a];
            access(op, a, wd, rd, ill, ack);
            check("rand_ack", 32'(ack), 32'h1);
            check("rand_illegal", 32'(ill), 32'(expill));
            check("rand_rdata", rd, expv);
            if (!expill && we) begin
                newv = (op == 2'b01) ? wd : (op == 2'b10) ? (expv | wd) : (expv & ~wd);
                mdl[a] = (expv & ~wmask(a)) | (newv & wmask(a));
            end
        end

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // mtvec write and readback
        access(2'b01, 12'h305, 32'h8000_0003, rd, ill, ack);
        check("mtvec_rw_ack", 32'(ack), 32'h1);
        check("mtvec_rw_old", rd, 32'h0);
        check("mtvec_rw_ill", 32'(ill), 32'h0);
        access(2'b00, 12'h305, 32'h0, rd, ill, ack);
        check("mtvec_read", rd, 32'h8000_0001);

        // Set MIE, take a vectored interrupt trap
        access(2'b10, 12'h300, 32'h8, rd, ill, ack);
        check("mstatus_rs_old", rd, 32'h0000_1800);
        @(negedge clk);
        trap = 1'b1; trap_pc = 32'h106; trap_cause = 32'h8000_0007; trap_tval = 32'h55;
        @(posedge clk);
        #1 trap = 1'b0;
        check("trap_mepc", mepc, 32'h104);
        check("trap_vec_vectored", trap_vector, 32'h8000_001C);
        trap_cause = 32'h5;
        #1 check("trap_vec_exception", trap_vector, 32'h8000_0000);
        trap_cause = 32'h0;
        access(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check("mstatus_after_trap", rd, 32'h0000_1880);
        access(2'b00, 12'h342, 32'h0, rd, ill, ack);
        check("mcause", rd, 32'h8000_0007);
        access(2'b00, 12'h343, 32'h0, rd, ill, ack);
        check("mtval", rd, 32'h55);

        // mret restores MIE
        @(negedge clk); mret = 1'b1;
        @(posedge clk); #1 mret = 1'b0;
        access(2'b00, 12'h300, 32'h0, rd, ill, ack);
        check("mstatus_after_mret", rd, 32'h0000_1888);

        // Illegal / read-only handling
        access(2'b01, 12'hF14, 32'h1, rd, ill, ack);
        check("mhartid_rw_ill", 32'(ill), 32'h1);
        check("mhartid_rw_rdata", rd, 32'h0);
        access(2'b10, 12'hF14, 32'h0, rd, ill, ack);
        check("mhartid_rs0_ill", 32'(ill), 32'h0);
        check("mhartid_rs0_rdata", rd, 32'h5);
        access(2'b00, 12'h7FF, 32'h0, rd, ill, ack);
        check("unknown_ill", 32'(ill), 32'h1);
`ifndef CSR_TIMER_EN
        access(2'b00, 12'h7C0, 32'h0, rd, ill, ack);
        check("mtime_absent_ill", 32'(ill), 32'h1);
`endif
        access(2'b01, 12'h301, 32'h0, rd, ill, ack);
        check("misa_write_ill", 32'(ill), 32'h0);
        access(2'b00, 12'h301, 32'h0, rd, ill, ack);
        check("misa_read", rd, 32'h4000_0100);

        // mip view and interrupt pending
        irq_ext = 1'b1; irq_sw = 1'b1;
        access(2'b00, 12'h344, 32'h0, rd, ill, ack);
        check("mip_read", rd, 32'h0000_0808);
        check("pending_masked", 32'(irq_pending), 32'h0);
        access(2'b01, 12'h304, 32'h800, rd, ill, ack);
        @(posedge clk); #1;
        check("pending_ext", 32'(irq_pending), 32'h1);
        irq_ext = 1'b0; irq_sw = 1'b0;
        @(posedge clk); #1;
        check("pending_cleared", 32'(irq_pending), 32'h0);

        // mcycle carry into mcycleh
        access(2'b01, 12'hB00, 32'hFFFF_FFFF, rd, ill, ack);
        access(2'b01, 12'hB80, 32'h0, rd, ill, ack);
        @(posedge clk);
        access(2'b00, 12'hB80, 32'h0, rd, ill, ack);
        check("mcycleh_carry", rd, 32'h1);
        access(2'b00, 12'hB00, 32'h0, rd, ill, ack);
        check("mcycle_low", rd, 32'h1);

        // minstret write beats a same-cycle retire, then counts retires
        @(negedge clk);
        inst_retire = 1'b1; csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'hB02; csr_wdata = 32'h100;
        @(posedge clk); #1;
        csr_req = 1'b0; inst_retire = 1'b0;
        access(2'b00, 12'hB02, 32'h0, rd, ill, ack);
        check("minstret_write_wins", rd, 32'h100);
        @(negedge clk); inst_retire = 1'b1;
        repeat (3) @(posedge clk);
        #1 inst_retire = 1'b0;
        access(2'b00, 12'hB02, 32'h0, rd, ill, ack);
        check("minstret_count", rd, 32'h103);
        access(2'b00, 12'hB82, 32'h0, rd, ill, ack);
        check("minstreth", rd, 32'h0);

        // CSR write dropped when a trap coincides
        access(2'b01, 12'h340, 32'hABCD, rd, ill, ack);
        @(negedge clk);
        trap = 1'b1; trap_pc = 32'h200; trap_cause = 32'h2;
        csr_req = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h1234;
        @(posedge clk); #1;
        trap = 1'b0; csr_req = 1'b0;
        check("prio_ack", 32'(csr_ack), 32'h1);
        check("prio_rdata", csr_rdata, 32'hABCD);
        check("prio_illegal", 32'(csr_illegal), 32'h0);
        access(2'b00, 12'h340, 32'h0, rd, ill, ack);
        check("prio_dropped", rd, 32'hABCD);
        check("prio_mepc", mepc, 32'h200);

`ifdef CSR_TIMER_EN
        // Timer interrupt from mtime >= mtimecmp
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        access(2'b01, 12'h304, 32'h80, rd, ill, ack);
        access(2'b10, 12'h300, 32'h8, rd, ill, ack);
        access(2'b01, 12'h7C3, 32'h0, rd, ill, ack);
        access(2'b01, 12'h7C1, 32'd20, rd, ill, ack);
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk); #1;
            seen = irq_pending;
        end
        check("timer_pending_rise", 32'(seen), 32'h1);
        access(2'b01, 12'h7C3, 32'h1, rd, ill, ack);
        @(posedge clk); #1;
        check("timer_pending_fall", 32'(irq_pending), 32'h0);
`else
        seen = 1'b0;
`endif

        // Reset asserted while a response is pending
        @(negedge clk);
        csr_req = 1'b1; csr_op = 2'b00; csr_addr = 12'h300;
        @(posedge clk); #1;
        csr_req = 1'b0;
        check("midreset_ack_before", 32'(csr_ack), 32'h1);
        rst_n = 1'b0;
        #1 check("midreset_ack_cleared", 32'(csr_ack), 32'h0);
        @(negedge clk); rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
